// File: rtl/regfile_pkg.sv
// Shared types and constants for the LEGv8 register-file write-port controller.
// The round-robin pick rule lives here so the arbiter stays a thin register wrapper.
package regfile_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } wctrl_state_t;

  localparam int         REG_CNT   = 32;
  localparam int         IDX_W     = $clog2(REG_CNT);
  localparam logic [4:0] ZR_IDX    = 5'd31;
  localparam logic [4:0] INIT_LAST = 5'd30;

  // One-hot grant from two valids; on contention the requester that did not win last time goes.
  function automatic logic [1:0] rr_pick(input logic [1:0] valid, input logic last);
    logic [1:0] grant;
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
    return grant;
  endfunction

endpackage

// File: rtl/regfile_wr_ctrl_rr_arb2.sv
// Two-input round-robin arbiter: valid in, one-hot grant out.
// The last-winner register resets to 1 so requester 0 wins the first contest.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  logic last_r;
  logic [1:0] grant_s;

  // Combinational pick from the current valids and last winner.
  always_comb begin
    grant_s = rr_pick(valid, last_r);
  end

  assign grant = grant_s;

  // Remember the index of the most recent winner.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_r <= 1'b1;
    end else if (|grant_s) begin
      last_r <= grant_s[1];
    end else begin
      last_r <= last_r;
    end
  end

endmodule

// File: rtl/regfile_wr_ctrl.sv
// Write-port controller for the 32x64 register file: post-reset init sweep (xi = i),
// then round-robin arbitration of two writeback requesters onto a registered write port.
module regfile_wr_ctrl
  import regfile_pkg::*;
#(
  parameter int         N  = 64,
  parameter logic [4:0] ZR = ZR_IDX
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         v0_i,
  input  logic [4:0]   a0_i,
  input  logic [N-1:0] d0_i,
  output logic         r0_o,
  input  logic         v1_i,
  input  logic [4:0]   a1_i,
  input  logic [N-1:0] d1_i,
  output logic         r1_o,
  output logic         we3,
  output logic [4:0]   wa3,
  output logic [N-1:0] wd3,
  output logic         init_done
);

  wctrl_state_t     state_r;
  wctrl_state_t     state_nxt_s;
  logic [IDX_W-1:0] idx_r;
  logic             init_done_r;
  logic             grant_en_s;
  logic [1:0]       valid_s;
  logic [1:0]       grant_s;
  logic [4:0]       sel_addr_s;
  logic [N-1:0]     sel_data_s;

  // Grants open only once init_done is visible, and never while reset is asserted,
  // so nothing is acknowledged that the reset edge would throw away.
  assign grant_en_s = (state_r == RUN) && init_done_r && !reset;
  assign valid_s    = {v1_i, v0_i} & {2{grant_en_s}};

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .valid (valid_s),
    .grant (grant_s)
  );

  assign r0_o      = grant_s[0];
  assign r1_o      = grant_s[1];
  assign init_done = init_done_r;

  // Mux the granted requester's address and data.
  always_comb begin
    sel_addr_s = a0_i;
    sel_data_s = d0_i;
    if (grant_s[1]) begin
      sel_addr_s = a1_i;
      sel_data_s = d1_i;
    end else begin
      sel_addr_s = a0_i;
      sel_data_s = d0_i;
    end
  end

  // Next-state: leave INIT after the sweep presents the last register.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      INIT: begin
        if (idx_r == INIT_LAST) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = INIT;
        end
      end
      RUN:     state_nxt_s = RUN;
      default: state_nxt_s = INIT;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= INIT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Sweep counter advances only while initialising.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_r <= {IDX_W{1'b0}};
    end else if (state_r == INIT) begin
      idx_r <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
    end else begin
      idx_r <= idx_r;
    end
  end

  // init_done trails the RUN transition by one cycle, so the x30 sweep write is
  // presented before any requester can be granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      init_done_r <= 1'b0;
    end else if (state_r == RUN) begin
      init_done_r <= 1'b1;
    end else begin
      init_done_r <= init_done_r;
    end
  end

  // Registered write port; XZR writes are accepted but never enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      we3 <= 1'b0;
      wa3 <= 5'd0;
      wd3 <= {N{1'b0}};
    end else begin
      case (state_r)
        INIT: begin
          we3 <= 1'b1;
          wa3 <= idx_r;
          wd3 <= N'(idx_r);
        end
        RUN: begin
          if (|grant_s) begin
            we3 <= (sel_addr_s != ZR);
            wa3 <= sel_addr_s;
            wd3 <= sel_data_s;
          end else begin
            we3 <= 1'b0;
            wa3 <= wa3;
            wd3 <= wd3;
          end
        end
        default: begin
          we3 <= 1'b0;
          wa3 <= wa3;
          wd3 <= wd3;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// Directed scoreboard bench for regfile_wr_ctrl with a behavioural register file
// written from the DUT write port.
module tb_regfile_wr_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        v0_i, v1_i;
  logic [4:0]  a0_i, a1_i;
  logic [63:0] d0_i, d1_i;
  logic        r0_o, r1_o;
  logic        we3;
  logic [4:0]  wa3;
  logic [63:0] wd3;
  logic        init_done;

  int total = 0;
  int bad   = 0;

  logic [69:0] exp_q[$];
  logic [63:0] rf [32] = '{default: 64'd0};

  regfile_wr_ctrl #(.N(64), .ZR(5'd31)) dut (
    .clk       (clk),
    .reset     (reset),
    .v0_i      (v0_i),
    .a0_i      (a0_i),
    .d0_i      (d0_i),
    .r0_o      (r0_o),
    .v1_i      (v1_i),
    .a1_i      (a1_i),
    .d1_i      (d1_i),
    .r1_o      (r1_o),
    .we3       (we3),
    .wa3       (wa3),
    .wd3       (wd3),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  // Behavioural regfile: stores every enabled write, x31 included, so a stray XZR write shows up.
  always @(posedge clk) begin
    if (we3) rf[wa3] <= wd3;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic we, input logic [4:0] wa, input logic [63:0] wd);
    exp_q.push_back({we, wa, wd});
  endtask

  // One clock; then compare the write port against the scoreboard head (or idle).
  task automatic cycle();
    logic [69:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("we3", {63'd0, we3}, {63'd0, e[69]});
      if (e[69]) begin
        chk("wa3", {59'd0, wa3}, {59'd0, e[68:64]});
        chk("wd3", wd3, e[63:0]);
      end
    end else begin
      chk("we3_idle", {63'd0, we3}, 64'd0);
    end
  endtask

  task automatic req(input logic v0, input logic [4:0] a0, input logic [63:0] d0,
                     input logic v1, input logic [4:0] a1, input logic [63:0] d1,
                     input logic er0, input logic er1);
    v0_i = v0; a0_i = a0; d0_i = d0;
    v1_i = v1; a1_i = a1; d1_i = d1;
    #1;
    chk("r0_o", {63'd0, r0_o}, {63'd0, er0});
    chk("r1_o", {63'd0, r1_o}, {63'd0, er1});
  endtask

  initial begin
    reset = 1'b1;
    v0_i = 1'b0; a0_i = 5'd0; d0_i = 64'd0;
    v1_i = 1'b0; a1_i = 5'd0; d1_i = 64'd0;

    // Reset then idle: sweep x0..x30
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we3", {63'd0, we3}, 64'd0);
    chk("rst_wa3", {59'd0, wa3}, 64'd0);
    chk("rst_wd3", wd3, 64'd0);
    chk("rst_init_done", {63'd0, init_done}, 64'd0);
    chk("rst_r0", {63'd0, r0_o}, 64'd0);
    chk("rst_r1", {63'd0, r1_o}, 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 31; i++) push(1'b1, 5'(i), 64'(i));
    for (int i = 0; i < 31; i++) begin
      cycle();
      chk("init_done_low", {63'd0, init_done}, 64'd0);
    end
    cycle();
    chk("init_done_high", {63'd0, init_done}, 64'd1);
    chk("rd_x5", rf[5], 64'd5);
    chk("rd_x30", rf[30], 64'd30);
    chk("rd_x31", rf[31], 64'd0);

    // Single requester
    req(1'b1, 5'd2, 64'd27, 1'b0, 5'd0, 64'd0, 1'b1, 1'b0);
    push(1'b1, 5'd2, 64'd27);
    cycle();
    req(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
    cycle();
    chk("rd_x2", rf[2], 64'd27);

    // XZR drop (last becomes 1)
    req(1'b0, 5'd0, 64'd0, 1'b1, 5'd31, 64'd52, 1'b0, 1'b1);
    push(1'b0, 5'd31, 64'd52);
    cycle();
    req(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
    cycle();
    chk("rd_x31_drop", rf[31], 64'd0);

    // Contention: grants 0,1,0,1, each stalled requester waits one cycle
    req(1'b1, 5'd4, 64'd28, 1'b1, 5'd5, 64'd99, 1'b1, 1'b0);
    push(1'b1, 5'd4, 64'd28);
    cycle();
    req(1'b1, 5'd8, 64'd55, 1'b1, 5'd5, 64'd99, 1'b0, 1'b1);
    push(1'b1, 5'd5, 64'd99);
    cycle();
    req(1'b1, 5'd8, 64'd55, 1'b1, 5'd6, 64'd7, 1'b1, 1'b0);
    push(1'b1, 5'd8, 64'd55);
    cycle();
    req(1'b0, 5'd0, 64'd0, 1'b1, 5'd6, 64'd7, 1'b0, 1'b1);
    push(1'b1, 5'd6, 64'd7);
    cycle();
    req(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
    cycle();
    chk("rd_x4", rf[4], 64'd28);
    chk("rd_x5_c", rf[5], 64'd99);
    chk("rd_x6", rf[6], 64'd7);
    chk("rd_x8", rf[8], 64'd55);

    // Same-address collision with last=1
    req(1'b1, 5'd7, 64'd100, 1'b1, 5'd7, 64'd200, 1'b1, 1'b0);
    push(1'b1, 5'd7, 64'd100);
    cycle();
    req(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'd200, 1'b0, 1'b1);
    push(1'b1, 5'd7, 64'd200);
    cycle();
    chk("rd_x7_first", rf[7], 64'd100);
    req(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
    cycle();
    chk("rd_x7_second", rf[7], 64'd200);

    // Reset in the middle of a grant stream on x9
    for (int k = 0; k < 3; k++) begin
      req(1'b1, 5'd9, 64'(500 + k), 1'b0, 5'd0, 64'd0, 1'b1, 1'b0);
      push(1'b1, 5'd9, 64'(500 + k));
      cycle();
    end
    d0_i = 64'd503;
    reset = 1'b1;
    cycle();
    chk("mid_r0", {63'd0, r0_o}, 64'd0);
    chk("mid_r1", {63'd0, r1_o}, 64'd0);
    chk("mid_init_done", {63'd0, init_done}, 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 31; i++) push(1'b1, 5'(i), 64'(i));
    for (int i = 0; i < 31; i++) begin
      cycle();
      chk("reinit_r0", {63'd0, r0_o}, 64'd0);
    end
    v0_i = 1'b0;
    cycle();
    chk("reinit_done", {63'd0, init_done}, 64'd1);
    chk("rd_x9", rf[9], 64'd9);
    chk("rd_x7_reinit", rf[7], 64'd7);
    chk("rd_x30_reinit", rf[30], 64'd30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
